// File: rtl/mem_copy_engine.sv
// mem_copy_engine: drives one port of a single-port RAM (asynchronous read,
// synchronous write) to copy a block of words or fill a block with a constant.
// Words are handled in strictly ascending address order with a single word
// buffered. Overlapping copies therefore replicate source data when dst > src.
module mem_copy_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SPACE = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_SPACE-1:0] src_addr,
  input  logic [ADDR_SPACE-1:0] dst_addr,
  input  logic [ADDR_SPACE-1:0] length,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_SPACE-1:0] words_done,
  output logic [ADDR_SPACE-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam logic [ADDR_SPACE-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_SPACE-1:0] ADDR_ONE  = {{(ADDR_SPACE-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    FILL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Transfer context latched when a start is accepted.
  logic [ADDR_SPACE-1:0] src_reg, src_next;
  logic [ADDR_SPACE-1:0] dst_reg, dst_next;
  logic [ADDR_SPACE-1:0] remaining_reg, remaining_next;
  logic [ADDR_SPACE-1:0] words_done_reg, words_done_next;
  logic [DATA_WIDTH-1:0] buffer_reg, buffer_next;
  logic [DATA_WIDTH-1:0] fill_reg, fill_next;

  // Last values driven onto the RAM bus, so address/data stay stable while
  // the engine sits in IDLE or DONE.
  logic [ADDR_SPACE-1:0] addr_hold_reg, addr_hold_next;
  logic [DATA_WIDTH-1:0] data_hold_reg, data_hold_next;

  // All outputs are decoded from registered state, so an asynchronous reset
  // drops mem_wren and busy immediately without waiting for a clock edge.
  assign words_done = words_done_reg;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, RAM bus outputs and datapath next values.
  always_comb begin
    state_next      = state_reg;
    busy            = 1'b0;
    done            = 1'b0;
    mem_wren        = 1'b0;
    mem_address     = addr_hold_reg;
    mem_data        = data_hold_reg;
    src_next        = src_reg;
    dst_next        = dst_reg;
    remaining_next  = remaining_reg;
    words_done_next = words_done_reg;
    buffer_next     = buffer_reg;
    fill_next       = fill_reg;

    case (state_reg)
      IDLE: begin
        // abort is deliberately not looked at here: start always wins.
        if (start) begin
          src_next        = src_addr;
          dst_next        = dst_addr;
          remaining_next  = length;
          fill_next       = fill_data;
          words_done_next = ADDR_ZERO;
          if (length == ADDR_ZERO) begin
            state_next = DONE;
          end else if (mode) begin
            state_next = FILL;
          end else begin
            state_next = READ;
          end
        end
      end

      READ: begin
        busy        = 1'b1;
        mem_address = src_reg;
        buffer_next = mem_q;
        src_next    = src_reg + ADDR_ONE;
        state_next  = abort ? IDLE : WRITE;
      end

      WRITE: begin
        busy            = 1'b1;
        mem_address     = dst_reg;
        mem_data        = buffer_reg;
        mem_wren        = 1'b1;
        dst_next        = dst_reg + ADDR_ONE;
        remaining_next  = remaining_reg - ADDR_ONE;
        words_done_next = words_done_reg + ADDR_ONE;
        // An abort still lets this cycle's write land and be counted.
        if (abort) begin
          state_next = IDLE;
        end else if (remaining_reg == ADDR_ONE) begin
          state_next = DONE;
        end else begin
          state_next = READ;
        end
      end

      FILL: begin
        busy            = 1'b1;
        mem_address     = dst_reg;
        mem_data        = fill_reg;
        mem_wren        = 1'b1;
        dst_next        = dst_reg + ADDR_ONE;
        remaining_next  = remaining_reg - ADDR_ONE;
        words_done_next = words_done_reg + ADDR_ONE;
        if (abort) begin
          state_next = IDLE;
        end else if (remaining_reg == ADDR_ONE) begin
          state_next = DONE;
        end else begin
          state_next = FILL;
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    addr_hold_next = mem_address;
    data_hold_next = mem_data;
  end

  // Datapath registers: transfer context, word buffer and bus hold values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      src_reg        <= '0;
      dst_reg        <= '0;
      remaining_reg  <= '0;
      words_done_reg <= '0;
      buffer_reg     <= '0;
      fill_reg       <= '0;
      addr_hold_reg  <= '0;
      data_hold_reg  <= '0;
    end else begin
      src_reg        <= src_next;
      dst_reg        <= dst_next;
      remaining_reg  <= remaining_next;
      words_done_reg <= words_done_next;
      buffer_reg     <= buffer_next;
      fill_reg       <= fill_next;
      addr_hold_reg  <= addr_hold_next;
      data_hold_reg  <= data_hold_next;
    end
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
Initiator-side block driving a single-port RAM: asynchronous read, synchronous write, single address bus. It performs block copy (read source word, write destination word) or block fill (constant word) over a programmable length. A simple start/busy/done control interface serves the control logic. The RAM port is owned exclusively by this block while busy; the top level handles any muxing.

Parameters:
DATA_WIDTH, 16, width of a memory word
ADDR_SPACE, 16, address width; memory holds 1 << ADDR_SPACE words

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
mode  input  1  0 = copy, 1 = fill
src_addr  input  ADDR_SPACE  first source word (copy only)
dst_addr  input  ADDR_SPACE  first destination word
length  input  ADDR_SPACE  number of words; 0 = no-op
fill_data  input  DATA_WIDTH  word written in fill mode
abort  input  1  terminate transfer early
busy  output  1  high in READ/WRITE/FILL
done  output  1  one-cycle pulse on normal completion
words_done  output  ADDR_SPACE  words written in current/last transfer
mem_address  output  ADDR_SPACE  RAM address
mem_data  output  DATA_WIDTH  RAM write data
mem_wren  output  1  RAM write enable
mem_q  input  DATA_WIDTH  RAM read data, combinational from mem_address

Behaviour:
- Reset (async, reset_n low): state IDLE; busy, done, mem_wren = 0; mem_address, mem_data, words_done = 0; internal src/dst/remaining/buffer cleared.
- States: IDLE, READ, WRITE, FILL, DONE.
- IDLE: if start at edge E0, latch src_addr, dst_addr, length, mode, fill_data; clear words_done; next = DONE if length==0, else FILL if mode, else READ. Input changes after E0 have no effect.
- READ (copy): mem_address = src, mem_wren = 0; at edge, buffer <= mem_q, src <= src+1; next WRITE.
- WRITE (copy): mem_address = dst, mem_data = buffer, mem_wren = 1; at edge dst+1, remaining-1, words_done+1; next READ, or DONE if remaining reaches 0.
- FILL: mem_address = dst, mem_data = latched fill_data, mem_wren = 1 every cycle; same counter updates; next DONE when remaining reaches 0.
- DONE: done = 1, busy = 0, mem_wren = 0 for exactly one cycle; next IDLE. start in DONE is ignored.
- In IDLE/DONE, mem_wren = 0 and mem_address holds its last value.
- Timing (start at E0): copy of N words writes at E2, E4 … E2N; done high between E2N and E2N+1. Fill of N writes at E1 … EN; done between EN and EN+1. Length 0: done between E0 and E1, no writes.
- Address arithmetic is modulo 1 << ADDR_SPACE: all-ones + 1 wraps to 0 silently.
- Overlap: strictly ascending word order, one word buffered. dst > src with overlap replicates source data; this is defined behaviour, not an error.
- abort high in READ/WRITE/FILL: next state IDLE at that edge, no done pulse. A write presented in that cycle completes. words_done includes it.
- abort in IDLE/DONE: ignored. abort and start together in IDLE: start wins.
- start while busy: ignored, no queuing.
- reset_n low mid-transfer: immediate IDLE, mem_wren drops asynchronously, partial data stays in RAM.
- words_done holds its final value until the next accepted start.

Test Plan:
- Copy: RAM[0x10..0x13] = 0xA1,0xB2,0xC3,0xD4; start, mode 0, src 0x10, dst 0x40, length 4 -> RAM[0x40..0x43] match; mem_wren high on 4 alternating cycles; done one pulse 9 cycles after start edge; words_done = 4.
- Fill: mode 1, dst 0x20, length 3, fill_data 0x5A5A -> RAM[0x20..0x22] = 0x5A5A; 0x23 untouched; done 4 cycles after start.
- Length 0: start -> done pulse next cycle, busy never high, no mem_wren.
- Wrap: copy src 0xFFFE, dst 0x0100, length 4 -> sources 0xFFFE, 0xFFFF, 0x0000, 0x0001 land at 0x0100..0x0103.
- Abort: fill length 10, abort on 3rd FILL cycle -> exactly 3 words written, words_done = 3, no done, IDLE next; fresh start accepted.
- Robustness: start pulses during busy ignored; reset_n low mid-copy -> mem_wren low immediately, all outputs 0, next start behaves normally.
